// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Port indices match the one-hot grant bit positions.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } arbState_e;

  localparam int PORT_D = 0;
  localparam int PORT_I = 1;
  localparam int PORT_G = 2;

  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_arb_pick.sv
// Requester picker: graphics always first,
// CPU data/fetch ports alternate on a tie.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       dReq,
  input  logic       iReq,
  input  logic       gReq,
  input  logic       lastCpu,
  output logic [2:0] grant
);

  // lastCpu=1 means data port won last, so fetch goes next
  always_comb begin
    grant = '0;
    if (gReq) begin
      grant[PORT_G] = 1'b1;
    end else if (dReq && iReq) begin
      if (lastCpu) grant[PORT_I] = 1'b1;
      else         grant[PORT_D] = 1'b1;
    end else if (iReq) begin
      grant[PORT_I] = 1'b1;
    end else if (dReq) begin
      grant[PORT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port sequencer for the asynchronous board SRAM.
// One access at a time: IDLE, SETUP, ACCESS x N, DONE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRdata,
  input  logic              gReq,
  input  logic [ADDR_W-1:0] gAddr,
  output logic              gAck,
  output logic [DATA_W-1:0] gRdata,
  inout  wire  [DATA_W-1:0] memDataBus,
  output logic [ADDR_W-1:0] memAddrBus,
  output logic              memEnable,
  output logic              memRead,
  output logic              memWrite
);

  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WAIT_CYCLES - 1);

  arbState_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        pick;
  logic [2:0]        grant;
  logic [2:0]        ackReg;
  logic              weReg;
  logic              drvEn;
  logic              lastCpu;
  logic [DATA_W-1:0] wdataReg;
  logic [ADDR_W-1:0] selAddr;
  logic              selWe;

  sram_arb_pick uPick (
    .dReq    (dReq),
    .iReq    (iReq),
    .gReq    (gReq),
    .lastCpu (lastCpu),
    .grant   (pick)
  );

  // Address and direction of whichever port is picked
  always_comb begin
    selAddr = dAddr;
    selWe   = dWe;
    if (pick[PORT_G]) begin
      selAddr = gAddr;
      selWe   = 1'b0;
    end else if (pick[PORT_I]) begin
      selAddr = iAddr;
      selWe   = 1'b0;
    end
  end

  // Bus is only driven by us while a write is in flight
  assign memDataBus = drvEn ? wdataReg : 'z;

  assign dAck = ackReg[PORT_D];
  assign iAck = ackReg[PORT_I];
  assign gAck = ackReg[PORT_G];

  // Access sequencer with registered strobes and read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= '0;
      ackReg     <= '0;
      weReg      <= 1'b0;
      drvEn      <= 1'b0;
      lastCpu    <= 1'b1;
      wdataReg   <= '0;
      memAddrBus <= '0;
      memEnable  <= 1'b1;
      memRead    <= 1'b1;
      memWrite   <= 1'b1;
      dRdata     <= '0;
      iRdata     <= '0;
      gRdata     <= '0;
    end else begin
      ackReg <= '0;
      unique case (state)
        IDLE: begin
          if (|pick) begin
            grant      <= pick;
            weReg      <= selWe;
            drvEn      <= selWe;
            wdataReg   <= dWdata;
            memAddrBus <= selAddr;
            memEnable  <= 1'b0;
            memRead    <= selWe;
            if (pick[PORT_D])      lastCpu <= 1'b1;
            else if (pick[PORT_I]) lastCpu <= 1'b0;
            state <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= '0;
          memWrite <= ~weReg;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            memRead  <= 1'b1;
            memWrite <= 1'b1;
            ackReg   <= grant;
            if (!weReg) begin
              if (grant[PORT_D]) dRdata <= memDataBus;
              if (grant[PORT_I]) iRdata <= memDataBus;
              if (grant[PORT_G]) gRdata <= memDataBus;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          memEnable <= 1'b1;
          drvEn     <= 1'b0;
          grant     <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the pins,
// reference memory and arbitration rules kept in the bench.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int WC  = 2;
  localparam int LAT = WC + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dReq = 1'b0, dWe = 1'b0;
  logic [AW-1:0] dAddr = '0;
  logic [DW-1:0] dWdata = '0;
  logic          dAck;
  logic [DW-1:0] dRdata;
  logic          iReq = 1'b0;
  logic [AW-1:0] iAddr = '0;
  logic          iAck;
  logic [DW-1:0] iRdata;
  logic          gReq = 1'b0;
  logic [AW-1:0] gAddr = '0;
  logic          gAck;
  logic [DW-1:0] gRdata;
  wire  [DW-1:0] memDataBus;
  logic [AW-1:0] memAddrBus;
  logic          memEnable, memRead, memWrite;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  logic [DW-1:0] sramMem [0:(1<<AW)-1];
  logic [DW-1:0] refMem  [0:(1<<AW)-1];
  logic [DW-1:0] expRd   [3];
  int            lastCpuModel;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dWdata(dWdata), .dAck(dAck), .dRdata(dRdata),
    .iReq(iReq), .iAddr(iAddr),
    .iAck(iAck), .iRdata(iRdata),
    .gReq(gReq), .gAddr(gAddr),
    .gAck(gAck), .gRdata(gRdata),
    .memDataBus(memDataBus), .memAddrBus(memAddrBus),
    .memEnable(memEnable), .memRead(memRead),
    .memWrite(memWrite)
  );

  // asynchronous SRAM: drives on read, latches on write release
  wire sramDrive = !memEnable && !memRead;
  assign memDataBus = sramDrive ? sramMem[memAddrBus] : 'z;

  always @(posedge memWrite)
    if (armed && !memEnable) sramMem[memAddrBus] = memDataBus;

  // whenever the SRAM is reading, nobody else may be on the bus
  always @(negedge clk) begin
    if (armed && rst && !memRead) begin
      vectors++;
      if (memWrite !== 1'b1 ||
          memDataBus !== sramMem[memAddrBus]) begin
        miscompares++;
        $display("FAIL busTurn: wr=%b bus=%h need wr=1 bus=%h",
                 memWrite, memDataBus, sramMem[memAddrBus]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic setReq(input int p, input logic r,
                        input logic we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    case (p)
      PORT_D: begin
        dReq = r; dWe = we; dAddr = a; dWdata = wd;
      end
      PORT_I: begin iReq = r; iAddr = a; end
      default: begin gReq = r; gAddr = a; end
    endcase
  endtask

  function automatic logic ackOf(input int p);
    case (p)
      PORT_D:  return dAck;
      PORT_I:  return iAck;
      default: return gAck;
    endcase
  endfunction

  function automatic logic [DW-1:0] rdataOf(input int p);
    case (p)
      PORT_D:  return dRdata;
      PORT_I:  return iRdata;
      default: return gRdata;
    endcase
  endfunction

  // graphics first; CPU tie goes to the port not served last
  function automatic int pickModel(input logic [2:0] r,
                                   input int lastPort);
    if (r[PORT_G]) return PORT_G;
    if (r[PORT_D] && r[PORT_I])
      return (lastPort == PORT_D) ? PORT_I : PORT_D;
    if (r[PORT_I]) return PORT_I;
    if (r[PORT_D]) return PORT_D;
    return -1;
  endfunction

  // one isolated request; returns observations, no checking
  task automatic issue(input int p, input logic we,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] wd,
                       output int lat,
                       output logic [DW-1:0] rd,
                       output int rdLow, output int wrLow,
                       output int badData);
    int n;
    bit got;
    n = 0; got = 1'b0;
    lat = -1; rd = '0;
    rdLow = 0; wrLow = 0; badData = 0;
    setReq(p, 1'b1, we, a, wd);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!memRead)  rdLow++;
      if (!memWrite) wrLow++;
      if (we && !memEnable &&
          (memDataBus !== wd || memAddrBus !== a))
        badData++;
      if (ackOf(p)) begin
        got = 1'b1; lat = n; rd = rdataOf(p);
      end
    end
    @(posedge clk); #1;
    setReq(p, 1'b0, 1'b0, '0, '0);
    if (p != PORT_G) lastCpuModel = p;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({memEnable, memRead, memWrite} !== 3'b111) begin
      miscompares++;
      $display("FAIL rstStrobe: got %b need 111",
               {memEnable, memRead, memWrite});
    end
    vectors++;
    if (memAddrBus !== '0 ||
        {gAck, iAck, dAck} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstAddrAck: addr=%h ack=%b need 0",
               memAddrBus, {gAck, iAck, dAck});
    end
    vectors++;
    if (dRdata !== '0 || iRdata !== '0 || gRdata !== '0) begin
      miscompares++;
      $display("FAIL rstRdata: %h %h %h need 0",
               dRdata, iRdata, gRdata);
    end
    rst = 1'b1;
    armed = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    int lat, rl, wl, bd;
    logic [DW-1:0] rd;
    sramMem[18'h00010] = 16'h1234;
    refMem[18'h00010]  = 16'h1234;
    issue(PORT_I, 1'b0, 18'h00010, '0, lat, rd, rl, wl, bd);
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL readLat: got %0d need %0d", lat, LAT);
    end
    vectors++;
    if (rd !== 16'h1234) begin
      miscompares++;
      $display("FAIL readData: got %h need 1234", rd);
    end
    expRd[PORT_I] = 16'h1234;
    vectors++;
    if (rl != WC + 1 || wl != 0) begin
      miscompares++;
      $display("FAIL readStrobes: rdLow=%0d wrLow=%0d need %0d/0",
               rl, wl, WC + 1);
    end
  endtask

  task automatic test_single_write;
    int lat, rl, wl, bd;
    logic [DW-1:0] rd;
    issue(PORT_D, 1'b1, 18'h3FFFF, 16'hBEEF,
          lat, rd, rl, wl, bd);
    refMem[18'h3FFFF] = 16'hBEEF;
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL writeLat: got %0d need %0d", lat, LAT);
    end
    vectors++;
    if (wl != WC || rl != 0) begin
      miscompares++;
      $display("FAIL writeStrobes: wrLow=%0d rdLow=%0d need %0d/0",
               wl, rl, WC);
    end
    vectors++;
    if (bd != 0) begin
      miscompares++;
      $display("FAIL writeHold: %0d bad cycles need 0", bd);
    end
    vectors++;
    if (rd !== expRd[PORT_D]) begin
      miscompares++;
      $display("FAIL writeRdata: dRdata=%h need %h",
               rd, expRd[PORT_D]);
    end
    issue(PORT_G, 1'b0, 18'h3FFFF, '0, lat, rd, rl, wl, bd);
    expRd[PORT_G] = refMem[18'h3FFFF];
    vectors++;
    if (rd !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL writeBack: got %h need BEEF", rd);
    end
  endtask

  task automatic test_contention;
    logic [AW-1:0] a [3];
    logic [2:0] left;
    int n, k, e;
    logic [2:0] act;
    a[PORT_D] = 18'h00100;
    a[PORT_I] = 18'h00200;
    a[PORT_G] = 18'h00300;
    for (int p = 0; p < 3; p++)
      setReq(p, 1'b1, 1'b0, a[p], '0);
    left = 3'b111; n = 0; k = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      act = {gAck, iAck, dAck};
      if (act != 3'b000) begin
        e = pickModel(left, lastCpuModel);
        vectors++;
        if (act !== 3'(1 << e) || n != LAT * (k + 1)) begin
          miscompares++;
          $display("FAIL contOrder: ack=%b at %0d need %b at %0d",
                   act, n, 3'(1 << e), LAT * (k + 1));
        end
        vectors++;
        if (rdataOf(e) !== refMem[a[e]]) begin
          miscompares++;
          $display("FAIL contData: port %0d got %h need %h",
                   e, rdataOf(e), refMem[a[e]]);
        end
        expRd[e] = refMem[a[e]];
        left[e] = 1'b0;
        if (e != PORT_G) lastCpuModel = e;
        k++;
      end
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++)
        if (!left[p]) setReq(p, 1'b0, 1'b0, '0, '0);
    end
    vectors++;
    if (k != 3) begin
      miscompares++;
      $display("FAIL contTimeout: %0d acks need 3", k);
    end
  endtask

  task automatic test_fairness;
    int n, k, e, got, prevN;
    logic [AW-1:0] ad, ai;
    ad = 18'h01234; ai = 18'h05678;
    setReq(PORT_D, 1'b1, 1'b0, ad, '0);
    setReq(PORT_I, 1'b1, 1'b0, ai, '0);
    n = 0; k = 0; prevN = 0;
    while (k < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (dAck || iAck || gAck) begin
        e = pickModel(3'b011, lastCpuModel);
        got = dAck ? PORT_D : PORT_I;
        vectors++;
        if ({gAck, iAck, dAck} !== 3'(1 << e)) begin
          miscompares++;
          $display("FAIL fairOrder%0d: ack=%b need %b",
                   k, {gAck, iAck, dAck}, 3'(1 << e));
        end
        if (k > 0) begin
          vectors++;
          if (n - prevN != LAT) begin
            miscompares++;
            $display("FAIL fairGap%0d: got %0d need %0d",
                     k, n - prevN, LAT);
          end
        end
        vectors++;
        if (rdataOf(got) !==
            refMem[(got == PORT_D) ? ad : ai]) begin
          miscompares++;
          $display("FAIL fairData%0d: got %h", k, rdataOf(got));
        end
        expRd[got] = refMem[(got == PORT_D) ? ad : ai];
        lastCpuModel = got;
        prevN = n;
        k++;
      end
      @(posedge clk); #1;
      if (k == 6) begin
        setReq(PORT_D, 1'b0, 1'b0, '0, '0);
        setReq(PORT_I, 1'b0, 1'b0, '0, '0);
      end
    end
    vectors++;
    if (k != 6) begin
      miscompares++;
      $display("FAIL fairTimeout: %0d acks need 6", k);
      setReq(PORT_D, 1'b0, 1'b0, '0, '0);
      setReq(PORT_I, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_random_single;
    int p, lat, rl, wl, bd;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    for (int k = 0; k < 20; k++) begin
      p  = $urandom_range(2);
      we = (p == PORT_D) && ($urandom_range(1) == 1);
      a  = AW'($urandom);
      wd = DW'($urandom);
      issue(p, we, a, wd, lat, rd, rl, wl, bd);
      vectors++;
      if (we) begin
        refMem[a] = wd;
        if (lat != LAT || rd !== expRd[PORT_D] || bd != 0) begin
          miscompares++;
          $display("FAIL rndWr%0d: lat=%0d rd=%h bd=%0d need %0d %h 0",
                   k, lat, rd, bd, LAT, expRd[PORT_D]);
        end
      end else begin
        if (lat != LAT || rd !== refMem[a]) begin
          miscompares++;
          $display("FAIL rndRd%0d: port %0d lat=%0d rd=%h need %0d %h",
                   k, p, lat, rd, LAT, refMem[a]);
        end
        expRd[p] = refMem[a];
      end
    end
  endtask

  task automatic test_random_contention;
    logic [2:0]    reqSig, act, expVec;
    bit            pending [3];
    logic [AW-1:0] pAddr [3];
    logic          pWe;
    logic [DW-1:0] pWd;
    int freeAt, expPort, expAck, w;
    bit anyLeft;
    reqSig = '0; freeAt = 0; expPort = -1; expAck = -1;
    pWe = 1'b0; pWd = '0;
    for (int p = 0; p < 3; p++) begin
      pending[p] = 1'b0; pAddr[p] = '0;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pending[p] && reqSig[p]) begin
          reqSig[p] = 1'b0;
          setReq(p, 1'b0, 1'b0, '0, '0);
        end else if (!pending[p] && cyc < 160 &&
                     $urandom_range(3) == 0) begin
          pending[p] = 1'b1;
          reqSig[p]  = 1'b1;
          pAddr[p]   = AW'($urandom);
          if (p == PORT_D) begin
            pWe = ($urandom_range(1) == 1);
            pWd = DW'($urandom);
          end
          setReq(p, 1'b1, (p == PORT_D) ? pWe : 1'b0,
                 pAddr[p], (p == PORT_D) ? pWd : '0);
        end
      end
      @(negedge clk);
      act    = {gAck, iAck, dAck};
      expVec = (cyc == expAck) ? 3'(1 << expPort) : 3'b000;
      vectors++;
      if (act !== expVec) begin
        miscompares++;
        $display("FAIL rcAck@%0d: got %b need %b", cyc, act, expVec);
      end
      if (cyc == expAck) begin
        if (expPort == PORT_D && pWe) begin
          refMem[pAddr[PORT_D]] = pWd;
        end else begin
          expRd[expPort] = refMem[pAddr[expPort]];
        end
        vectors++;
        if (rdataOf(expPort) !== expRd[expPort]) begin
          miscompares++;
          $display("FAIL rcData@%0d: port %0d got %h need %h",
                   cyc, expPort, rdataOf(expPort), expRd[expPort]);
        end
        pending[expPort] = 1'b0;
        if (expPort != PORT_G) lastCpuModel = expPort;
      end
      if (cyc >= freeAt && reqSig != 3'b000) begin
        w = pickModel(reqSig, lastCpuModel);
        expPort = w;
        expAck  = cyc + LAT - 1;
        freeAt  = cyc + LAT;
      end
      @(posedge clk); #1;
    end
    anyLeft = pending[0] || pending[1] || pending[2];
    vectors++;
    if (anyLeft) begin
      miscompares++;
      $display("FAIL rcDrain: requests left unserved");
    end
    for (int p = 0; p < 3; p++) setReq(p, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int n, lows, acks, lat, rl, wl, bd;
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    a = 18'h02A5C;
    n = 0; lows = 0; acks = 0;
    setReq(PORT_I, 1'b1, 1'b0, a, '0);
    while (lows < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (!memRead) lows++;
    end
    vectors++;
    if (lows != 2) begin
      miscompares++;
      $display("FAIL midWait: saw %0d read cycles need 2", lows);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({memEnable, memRead, memWrite} !== 3'b111 ||
        memAddrBus !== '0) begin
      miscompares++;
      $display("FAIL midStrobe: %b addr=%h need 111 0",
               {memEnable, memRead, memWrite}, memAddrBus);
    end
    for (int p = 0; p < 3; p++) expRd[p] = '0;
    lastCpuModel = PORT_D;
    vectors++;
    if ({gAck, iAck, dAck} !== 3'b000 || iRdata !== '0) begin
      miscompares++;
      $display("FAIL midAck: ack=%b iRdata=%h need 000 0",
               {gAck, iAck, dAck}, iRdata);
    end
    setReq(PORT_I, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (dAck || iAck || gAck) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL midNoAck: %0d acks need 0", acks);
    end
    @(posedge clk); #1;
    issue(PORT_I, 1'b0, a, '0, lat, rd, rl, wl, bd);
    vectors++;
    if (lat != LAT || rd !== refMem[a]) begin
      miscompares++;
      $display("FAIL midRecover: lat=%0d rd=%h need %0d %h",
               lat, rd, LAT, refMem[a]);
    end
    expRd[PORT_I] = refMem[a];
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      sramMem[a] = DW'(a * 7919 + 13);
      refMem[a]  = DW'(a * 7919 + 13);
    end
    for (int p = 0; p < 3; p++) expRd[p] = '0;
    lastCpuModel = PORT_D;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_fairness();
    test_random_single();
    test_random_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences the single asynchronous external SRAM (18-bit address, 16-bit bidirectional data, active-low enable/read/write strobes) and shares it between three requesters: CPU data port, CPU instruction-fetch port and the graphics framebuffer reader. It sits between the CPU/graphics blocks and the board SRAM pins and replaces direct pin driving by the memory controller. Each requester uses a req/ack handshake; the arbiter serialises accesses and enforces SRAM setup and strobe timing.

## Interface
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 2, strobe-active cycles per access (>=1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- dReq, dWe  in  1  CPU data request / write-enable (1 = write)
- dAddr  in  ADDR_W  CPU data address
- dWdata  in  DATA_W  CPU write data
- dAck  out  1  one-cycle completion pulse
- dRdata  out  DATA_W  CPU read data
- iReq  in  1  fetch request (read only)
- iAddr  in  ADDR_W  fetch address
- iAck  out  1  completion pulse
- iRdata  out  DATA_W  fetch data
- gReq  in  1  graphics request (read only)
- gAddr  in  ADDR_W  graphics address
- gAck  out  1  completion pulse
- gRdata  out  DATA_W  graphics data
- memDataBus  inout  DATA_W  SRAM data
- memAddrBus  out  ADDR_W  SRAM address
- memEnable, memRead, memWrite  out  1  SRAM strobes, active-low

## Operation
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles, counter) -> DONE -> IDLE.
- IDLE: requests sampled; if any asserted, grant latched, address/write data/direction registered, go SETUP. No request: stay IDLE.
- Priority: gReq always wins; between dReq and iReq round-robin via lastCpu flag (toggles to the other CPU port after each CPU grant); after reset iReq wins a tie.
- SETUP: memAddrBus driven, memEnable=0; read: memRead=0; write: memDataBus driven, memWrite=1.
- ACCESS: read keeps memRead=0, memDataBus high-Z; write asserts memWrite=0, data driven. Read data captured into granted port's Rdata register on the last ACCESS edge.
- DONE: memWrite/memRead=1, write data still driven (hold), memEnable=0; granted port's Ack=1 for exactly this cycle.
- Requester contract: req and address/data held stable until Ack; req deasserted the cycle after Ack. Request dropped mid-access: access completes, Ack still pulses.
- xRdata holds last read value until that port's next read completes; writes leave dRdata unchanged.
- Addresses and data pass through unmodified; no width conversion.

## Timing
- Reset (async, immediate): state IDLE, memEnable/memRead/memWrite=1, memDataBus high-Z, memAddrBus=0, all Ack=0, all Rdata=0, lastCpu selects iReq.
- Latency: req sampled high in IDLE -> Ack WAIT_CYCLES+3 cycles later (5 at default). Throughput: one access per WAIT_CYCLES+3 cycles.
- Reset mid-access aborts; no Ack; SRAM write may be partial.
- Bus turnaround: memDataBus driven only in SETUP/ACCESS/DONE of writes; IDLE always high-Z.

## Structure
- Package sram_arb_pkg: state enum, port index constants (PORT_D, PORT_I, PORT_G), default WAIT_CYCLES.
- Sub-module sram_arb_pick: combinational priority + round-robin picker (inputs three reqs, lastCpu; output one-hot grant).
- Sequencer, tri-state driver, Rdata registers in sram_arbiter.

## Test plan
- Single read: iReq, iAddr=0x00010, SRAM model holds 0x1234 -> iAck exactly 5 cycles after request, iRdata=0x1234, memRead low for 3 cycles.
- Single write: dReq, dWe=1, dAddr=0x3FFFF, dWdata=0xBEEF -> memWrite low 2 cycles, data stable SETUP..DONE, later read returns 0xBEEF.
- Contention: dReq, iReq, gReq same cycle -> grants order G, I, D; each Ack 5 cycles apart.
- Fairness: dReq and iReq held continuously for 6 accesses -> grants alternate I, D, I, D, I, D.
- Reset mid-ACCESS: rst low during read -> strobes high and bus high-Z same cycle, no Ack, state IDLE after release.
- Bus contention check: no cycle where memDataBus is driven while memRead=0.
